// File: rtl/sim_run_ctrl.sv
// Run controller for a Calyx `main`: sequences its reset, holds go until done, counts run cycles.
// Define SIM_RUN_CTRL_LIMIT_EN to compile in the cycle-limit abort (TIMEOUT state).
module sim_run_ctrl #(
    parameter int RESET_CYCLES = 5,
    parameter int COUNT_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] cycle_limit,
    output logic                   main_reset,
    output logic                   main_go,
    input  logic                   main_done,
    output logic [COUNT_WIDTH-1:0] cycles,
    output logic                   busy,
    output logic                   finished,
    output logic                   timed_out
);

    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e                   state_q, state_d;
    logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
    logic [COUNT_WIDTH-1:0]   cycles_q, cycles_d, cycles_inc;
    logic                     main_reset_q, main_reset_d;
    logic                     main_go_q, main_go_d;
    logic                     busy_q, busy_d;
    logic                     finished_q, finished_d;
    logic                     timed_out_q, timed_out_d;
    logic                     limit_hit;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + COUNT_WIDTH'(1);

`ifdef SIM_RUN_CTRL_LIMIT_EN
    assign limit_hit = (cycle_limit != '0) && (cycles_inc == cycle_limit);
`else
    logic unused_cycle_limit;
    assign unused_cycle_limit = ^cycle_limit;
    assign limit_hit          = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cycles_d     = cycles_q;
        main_reset_d = 1'b0;
        main_go_d    = 1'b0;
        finished_d   = finished_q;
        timed_out_d  = timed_out_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d      = S_RESET;
                    rst_cnt_d    = RST_W'(RESET_CYCLES);
                    cycles_d     = '0;
                    finished_d   = 1'b0;
                    timed_out_d  = 1'b0;
                    main_reset_d = 1'b1;
                end
            end
            S_RESET: begin
                main_reset_d = 1'b1;
                if (rst_cnt_q == RST_W'(1)) begin
                    state_d      = S_RUN;
                    main_reset_d = 1'b0;
                    main_go_d    = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end
            S_RUN: begin
                cycles_d  = cycles_inc;
                main_go_d = 1'b1;
                // Done takes priority over a limit reached on the same edge.
                if (main_done) begin
                    state_d    = S_DONE;
                    main_go_d  = 1'b0;
                    finished_d = 1'b1;
                end else if (limit_hit) begin
                    state_d     = S_TIMEOUT;
                    main_go_d   = 1'b0;
                    timed_out_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RESET) || (state_d == S_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            cycles_q     <= '0;
            main_reset_q <= 1'b1;
            main_go_q    <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycles_q     <= cycles_d;
            main_reset_q <= main_reset_d;
            main_go_q    <= main_go_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign main_reset = main_reset_q;
    assign main_go    = main_go_q;
    assign cycles     = cycles_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Table-driven bench for sim_run_ctrl plus hand-written mid-run reset and saturation sequences.
module tb_sim_run_ctrl;

    localparam int RC = 5;
    localparam int CW = 8;
    localparam int OW = CW + 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          main_done = 1'b0;
    logic [CW-1:0] cycle_limit = '0;
    logic          main_reset, main_go, busy, finished, timed_out;
    logic [CW-1:0] cycles;

    int errors = 0;
    int checks = 0;

    sim_run_ctrl #(.RESET_CYCLES(RC), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cycle_limit (cycle_limit),
        .main_reset  (main_reset),
        .main_go     (main_go),
        .main_done   (main_done),
        .cycles      (cycles),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          dn;
        logic [CW-1:0] lim;
        logic [OW-1:0] exp;   // {main_reset, main_go, busy, finished, timed_out, cycles}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic dn, input int lim,
                                input logic mr, input logic go, input logic bz,
                                input logic fin, input logic to, input int cyc);
        vec_t v;
        v.st  = st;
        v.dn  = dn;
        v.lim = CW'(lim);
        v.exp = {mr, go, bz, fin, to, CW'(cyc)};
        vecs.push_back(v);
    endfunction

    // Start edge, remaining reset-phase edges, then the edge that enters RUN.
    function automatic void add_start(input int lim, input logic dn_at_entry);
        add(1'b1, 1'b0, lim, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i < RC; i++) add(1'b0, 1'b0, lim, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        add(1'b0, dn_at_entry, lim, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {rst,go,busy,fin,to,cyc}=%b_%0d required %b_%0d",
                     name, act[OW-1:CW], act[CW-1:0], exp[OW-1:CW], exp[CW-1:0]);
        end
    endtask

    function automatic logic [OW-1:0] outs();
        return {main_reset, main_go, busy, finished, timed_out, cycles};
    endfunction

    initial begin
        // Run 1: ten go cycles, a start pulse mid-run is ignored.
        add(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_start(0, 1'b0);
        for (int k = 1; k <= 9; k++) add(k == 4, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, k);
        add(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        add(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        // Run 2: restart from DONE, done already high when RUN begins.
        add_start(0, 1'b1);
        add(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        // Run 3: limit 7, done never asserted.
        add_start(7, 1'b0);
        for (int k = 1; k <= 6; k++) add(1'b0, 1'b0, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, k);
`ifdef SIM_RUN_CTRL_LIMIT_EN
        add(1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7);
        add(1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7);
`else
        add(1'b0, 1'b0, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7);
        add(1'b0, 1'b0, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        add(1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9);
`endif
        // Run 4: limit 4 and done on go cycle 4 together: done wins.
        add_start(4, 1'b0);
        for (int k = 1; k <= 3; k++) add(1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, k);
        add(1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        // Run 5: limit lowered below the count mid-run never fires.
        add_start(0, 1'b0);
        for (int k = 1; k <= 3; k++) add(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, k);
        for (int k = 4; k <= 5; k++) add(1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, k);
        add(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6);

        // Reset values while reset is held.
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_vals", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0)});
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            start       = vecs[i].st;
            main_done   = vecs[i].dn;
            cycle_limit = vecs[i].lim;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        start     = 1'b0;
        main_done = 1'b0;
        cycle_limit = '0;

        // Asynchronous reset during go cycle 3.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (RC + 2) @(posedge clk);
        #1 check("pre_reset_run", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CW'(2)});
        #2 reset = 1'b1;
        #1 check("async_reset", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0)});
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check("idle_after_reset", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0)});

        // Counter saturates at all-ones and holds through done.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (RC + 260) @(posedge clk);
        #1 check("saturated", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CW'(255)});
        main_done = 1'b1;
        @(posedge clk);
        #1 check("done_saturated", outs(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CW'(255)});
        main_done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
